// File: rtl/cache_control.sv
// cache_control: control FSM for a 2-way, write-back, write-allocate cache.
// It sequences the lookup, writeback and fill steps around the rw_array
// instances. It also runs the CPU request/response handshake and the
// physical-memory burst handshake.
// Every output is combinational from the state register, the victim register
// and the current inputs. All outputs are forced low while rst is high.

module cache_control (
  input  logic       clk,
  input  logic       rst,
  // CPU side
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  // status from the datapath (registered array outputs)
  input  logic [1:0] hit,
  input  logic       victim_dirty,
  input  logic       lru_out,
  // physical memory side
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  // array control
  output logic       array_read,
  output logic [1:0] load_data,
  output logic [1:0] load_tag,
  output logic [1:0] load_valid,
  output logic [1:0] load_dirty,
  output logic       load_lru,
  output logic       dirty_in,
  output logic       lru_in,
  output logic       datain_sel,
  output logic       pmem_addr_sel,
  output logic       way_sel
);

  // FSM encoding
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CHECK     = 2'd1;
  localparam logic [1:0] S_WRITEBACK = 2'd2;
  localparam logic [1:0] S_FILL      = 2'd3;

  // registered state
  logic [1:0] r_state;
  logic       r_victim;

  // next-state values
  logic [1:0] w_state_next;
  logic       w_victim_next;

  // request / lookup decode
  logic       w_req;
  logic       w_hit_any;
  logic       w_hit_way;
  logic [1:0] w_hit_mask;
  logic [1:0] w_victim_mask;

  // raw outputs before reset gating
  logic       w_mem_resp;
  logic       w_pmem_read;
  logic       w_pmem_write;
  logic       w_array_read;
  logic [1:0] w_load_data;
  logic [1:0] w_load_tag;
  logic [1:0] w_load_valid;
  logic [1:0] w_load_dirty;
  logic       w_load_lru;
  logic       w_dirty_in;
  logic       w_lru_in;
  logic       w_datain_sel;
  logic       w_pmem_addr_sel;
  logic       w_way_sel;

  // A simultaneous read and write is served as a write. mem_write alone
  // selects the write path, so no separate priority logic is needed.
  assign w_req     = mem_read | mem_write;
  assign w_hit_any = |hit;
  // When both ways hit, way 0 wins.
  assign w_hit_way = ~hit[0];
  assign w_hit_mask    = w_hit_way ? 2'b10 : 2'b01;
  assign w_victim_mask = r_victim  ? 2'b10 : 2'b01;

  // State and victim registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_victim <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_victim <= w_victim_next;
    end
  end

  // Next-state selection and victim capture on a miss
  always_comb begin
    w_state_next  = r_state;
    w_victim_next = r_victim;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_hit_any) begin
          // The idle cycle after a response is mandatory.
          w_state_next = S_IDLE;
        end else begin
          // The victim way is the LRU way of the addressed set. It is held
          // across the writeback and fill, because the datapath's LRU
          // output is not stable once the arrays are being rewritten.
          w_victim_next = lru_out;
          w_state_next  = victim_dirty ? S_WRITEBACK : S_FILL;
        end
      end
      S_WRITEBACK: begin
        if (pmem_resp) begin
          w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        if (pmem_resp) begin
          // The re-lookup hits through the array read-during-write forward.
          w_state_next = S_CHECK;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output decode per state. pmem_resp outside WRITEBACK/FILL has no effect.
  always_comb begin
    w_mem_resp      = 1'b0;
    w_pmem_read     = 1'b0;
    w_pmem_write    = 1'b0;
    w_array_read    = 1'b0;
    w_load_data     = 2'b00;
    w_load_tag      = 2'b00;
    w_load_valid    = 2'b00;
    w_load_dirty    = 2'b00;
    w_load_lru      = 1'b0;
    w_dirty_in      = 1'b0;
    w_lru_in        = 1'b0;
    w_datain_sel    = 1'b0;
    w_pmem_addr_sel = 1'b0;
    w_way_sel       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Start the lookup. The array outputs are valid in the next cycle.
        w_array_read = w_req;
      end
      S_CHECK: begin
        if (w_hit_any) begin
          w_mem_resp = 1'b1;
          w_load_lru = 1'b1;
          // The other way becomes least recently used.
          w_lru_in   = ~w_hit_way;
          w_way_sel  = w_hit_way;
          if (mem_write) begin
            w_load_data  = w_hit_mask;
            w_load_dirty = w_hit_mask;
            w_dirty_in   = 1'b1;
            w_datain_sel = 1'b0;
          end
        end
      end
      S_WRITEBACK: begin
        w_pmem_write    = 1'b1;
        w_pmem_addr_sel = 1'b1;
        w_way_sel       = r_victim;
      end
      S_FILL: begin
        w_pmem_read     = 1'b1;
        w_pmem_addr_sel = 1'b0;
        if (pmem_resp) begin
          w_load_data  = w_victim_mask;
          w_load_tag   = w_victim_mask;
          w_load_valid = w_victim_mask;
          w_load_dirty = w_victim_mask;
          w_dirty_in   = 1'b0;
          w_datain_sel = 1'b1;
          w_array_read = 1'b1;
        end
      end
      default: begin
        w_mem_resp = 1'b0;
      end
    endcase
  end

  // Reset gating. The state register clears asynchronously, but IDLE still
  // decodes array_read from a live request. Gating with rst keeps every
  // output at 0 while reset is held. It also drops any pmem request in the
  // same cycle that rst asserts.
  assign mem_resp      = ~rst & w_mem_resp;
  assign pmem_read     = ~rst & w_pmem_read;
  assign pmem_write    = ~rst & w_pmem_write;
  assign array_read    = ~rst & w_array_read;
  assign load_data     = {2{~rst}} & w_load_data;
  assign load_tag      = {2{~rst}} & w_load_tag;
  assign load_valid    = {2{~rst}} & w_load_valid;
  assign load_dirty    = {2{~rst}} & w_load_dirty;
  assign load_lru      = ~rst & w_load_lru;
  assign dirty_in      = ~rst & w_dirty_in;
  assign lru_in        = ~rst & w_lru_in;
  assign datain_sel    = ~rst & w_datain_sel;
  assign pmem_addr_sel = ~rst & w_pmem_addr_sel;
  assign way_sel       = ~rst & w_way_sel;

endmodule
